// File: rtl/compound_exhaustive_checker.sv
// compound_exhaustive_checker: drives all 64 input vectors into the six-input compound NAND
// block, holds each one for SETTLE_CYCLES clocks, samples the block's outputs in a one-cycle
// CHECK slot and compares them with the golden equations. Reports pass/fail, a saturating
// mismatch count and the first failing vector.
// Optional feature: define CHECKER_PER_OUTPUT_ERR_EN to add err_bits[4:0], a sticky per-output
// mismatch map for the run.
module compound_exhaustive_checker #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned ERR_W         = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [5:0]       dut_in,
   input  logic [4:0]       dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             first_err_valid,
`ifdef CHECKER_PER_OUTPUT_ERR_EN
   output logic [5:0]       first_err_vec,
   output logic [4:0]       err_bits
`else
   output logic [5:0]       first_err_vec
`endif
);

   typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

   localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

   state_e           state_q, state_d;
   logic [5:0]       vec_q, vec_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;
   logic             fev_q, fev_d;
   logic [5:0]       fvec_q, fvec_d;
   logic [4:0]       ebits_q, ebits_d;
   logic [4:0]       golden;
   logic [4:0]       mismatch;
   logic             accept;

   // Golden outputs of the compound block for the vector currently driven.
   always_comb begin
      logic a, b, c, d, e, f;
      {a, b, c, d, e, f} = vec_q;
      golden[4] = (a & b) | (c & d);
      golden[3] = ((a & b & c) | (d & e)) & f;
      golden[2] = (~a & b) | (~c & ~e) | (~d & ~e);
      golden[1] = ~d | (a & ~b);
      golden[0] = (c & ~d) | (~b & ~d) | (a & b & ~c & d);
   end

   assign mismatch = dut_out ^ golden;
   // In DONE, start is only taken once done is visible so busy and done never overlap a restart.
   assign accept   = start & ((state_q == StIdle) | ((state_q == StDone) & done_q));

   // Next-state and result bookkeeping.
   always_comb begin
      state_d     = state_q;
      vec_d       = vec_q;
      cnt_d       = cnt_q;
      busy_d      = busy_q;
      done_d      = done_q;
      pass_d      = pass_q;
      err_count_d = err_count_q;
      fev_d       = fev_q;
      fvec_d      = fvec_q;
      ebits_d     = ebits_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (accept) begin
               state_d     = StSettle;
               vec_d       = '0;
               cnt_d       = '0;
               busy_d      = 1'b1;
               done_d      = 1'b0;
               pass_d      = 1'b0;
               err_count_d = '0;
               fev_d       = 1'b0;
               fvec_d      = '0;
               ebits_d     = '0;
            end else if (state_q == StDone) begin
               busy_d = 1'b0;
               done_d = 1'b1;
               pass_d = (err_count_q == '0);
            end
         end
         StSettle: begin
            if (cnt_q == SettleLast) begin
               cnt_d   = '0;
               state_d = StCheck;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StCheck: begin
            if (|mismatch) begin
               if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
               if (!fev_q) begin
                  fev_d  = 1'b1;
                  fvec_d = vec_q;
               end
            end
            ebits_d = ebits_q | mismatch;
            if (vec_q == 6'h3F) begin
               state_d = StDone;
            end else begin
               vec_d   = vec_q + 6'd1;
               state_d = StSettle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and result registers; reset discards any partial run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         vec_q       <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_count_q <= '0;
         fev_q       <= 1'b0;
         fvec_q      <= '0;
         ebits_q     <= '0;
      end else begin
         state_q     <= state_d;
         vec_q       <= vec_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         err_count_q <= err_count_d;
         fev_q       <= fev_d;
         fvec_q      <= fvec_d;
         ebits_q     <= ebits_d;
      end
   end

   assign dut_in          = vec_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign pass            = pass_q;
   assign err_count       = err_count_q;
   assign first_err_valid = fev_q;
   assign first_err_vec   = fvec_q;

`ifdef CHECKER_PER_OUTPUT_ERR_EN
   assign err_bits = ebits_q;
`else
   logic unused_ebits;
   assign unused_ebits = ^ebits_q;
`endif

endmodule

// File: doc/compound_exhaustive_checker.md
Name: compound_exhaustive_checker

Overview:
- Self-checking exhaustive stimulus/response engine for the six-input, five-output compound NAND logic block.
- Drives all 64 input vectors into the block under test, waits a settle interval, and samples its outputs.
- Compares each sample against internally computed golden equations and reports pass/fail, mismatch count and the first failing vector.
- Sits on the test side of the compound block, either on-chip as BIST or in a wrapper, driving its inputs and receiving its outputs.

Parameters:
- SETTLE_CYCLES, 1, number of clk cycles each vector is held before the output sample is taken (legal range 1..15).
- ERR_W, 7, width of err_count; the count saturates at all-ones.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a 64-vector run; sampled only in IDLE or DONE.
- dut_in  output  6  vector driven to the block under test; bit5=a, bit4=b, bit3=c, bit2=d, bit1=e, bit0=f.
- dut_out  input  5  outputs of the block under test; bit4=y1, bit3=y2, bit2=y3, bit1=y4, bit0=y5.
- busy  output  1  high from the cycle after start is accepted until done rises.
- done  output  1  high in DONE; held until the next accepted start or reset.
- pass  output  1  valid while done=1; 1 iff err_count==0.
- err_count  output  ERR_W  number of mismatching vectors in the current run.
- first_err_valid  output  1  set on the first mismatch of a run.
- first_err_vec  output  6  dut_in value of the first mismatch; frozen once first_err_valid=1.

Behaviour:
- Golden equations, combinational on the currently driven vector:
  - y1 = ab + cd
  - y2 = (abc + de)·f
  - y3 = a'b + c'e' + d'e'
  - y4 = d' + ab'
  - y5 = cd' + b'd' + abc'd
- Reset, asynchronous on rst_n low:
  - State goes to IDLE.
  - dut_in, busy, done, pass, err_count, first_err_valid and first_err_vec all go to 0.
  - Applies mid-run as well; the partial run is discarded with no stale results kept.
- State IDLE:
  - On start=1, clear err_count, first_err_valid and first_err_vec, set vec=0 and busy=1, then go to SETTLE.
- State SETTLE:
  - dut_in=vec, with vec driven from a register (not combinational).
  - The settle counter counts SETTLE_CYCLES cycles, then the FSM goes to CHECK.
- State CHECK (one cycle):
  - Compare dut_out against golden(vec).
  - On any bit mismatch, increment err_count (saturating). If first_err_valid=0, capture first_err_vec=vec and set first_err_valid=1.
  - If vec==63, go to DONE. Otherwise vec=vec+1 and go to SETTLE.
- State DONE:
  - busy=0, done=1, pass=(err_count==0).
  - start=1 clears the results and restarts exactly as from IDLE.
- Timing:
  - Each vector takes SETTLE_CYCLES+1 cycles.
  - done rises 64·(SETTLE_CYCLES+1)+1 cycles after the start-sampling edge, which is 129 cycles at the default setting.
- Boundary rules:
  - start while busy is ignored.
  - The vec increment never wraps mid-run; the run terminates at 63.
  - dut_out is sampled only in CHECK; values in other states are don't-care.
  - dut_in holds its last vector (63) in DONE.

Optional Feature:
- Macro: CHECKER_PER_OUTPUT_ERR_EN.
- Defined: adds output err_bits[4:0], using the same bit mapping as dut_out.
  - err_bits is the sticky OR of (dut_out XOR golden) over all CHECK cycles of the run.
  - Cleared on reset and on an accepted start.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Ideal compound model attached, SETTLE_CYCLES=1, pulse start -> done at start+129 cycles, pass=1, err_count=0, first_err_valid=0, dut_in=6'h3F.
- y1 forced to 0 -> err_count=28, first_err_vec=6'h0C, pass=0. With the macro defined, err_bits=5'b10000.
- y4 inverted -> err_count=64, first_err_vec=6'h00, first_err_valid=1.
- rst_n pulsed low at cycle 50 of a run -> all outputs 0 immediately. A fresh start then gives a full clean run matching the first scenario.
- start pulsed again at cycle 20 of a run -> ignored, with the same completion cycle. start in DONE -> results cleared and a new run begins next cycle.
- SETTLE_CYCLES=3, ideal model -> done at start+257 cycles, pass=1.
